adv_calc_p: RTL and testbench
=============================

Name: adv_calc_p

Overview:
Parametrised successor of the 2-operand hex key calculator. It accepts radix-2^KEY_W digit keys, four operators (add, mul, sub, and), equals and clear-key events. Further features: chained operations, repeat-equals, an overflow flag, and EVENT edge detection so a held key registers once. It sits between the keypad scanner, which supplies one EVENT strobe per key press, and the display driver, which consumes RESULT.

Parameters:
KEY_W, 4, bits per digit key (4 = hex entry)
NDIG, 2, max digits per entered operand; OPND_W = NDIG*KEY_W
RES_W, 16, accumulator/RESULT width; must be >= OPND_W (elaboration error otherwise)

Ports:
CLK  in  1  clock, all state on rising edge
CLR_N  in  1  asynchronous active-low reset
KEY  in  KEY_W  digit value, qualified by EVENT
OPK  in  1  1 = this event is an operator key
OP  in  2  operator: 00 add, 01 mul, 10 sub, 11 bitwise and
EQUAL  in  1  1 = this event is the equals key
CCLR  in  1  1 = this event is the clear key
EVENT  in  1  key-press strobe, level, may be held multiple cycles
RESULT  out  RES_W  displayed value
STATE  out  3  FSM state code
OVF  out  1  sticky overflow of last computation chain

Behaviour:
- Reset (CLR_N=0, async): ACC=0, B=0, pending op=add, last op=add, last B=0, digit counts=0, EVENT history=0. RESULT=0, STATE=0, OVF=0. Holds while low.
- Event detect: EVENT registered each cycle. A key action occurs on the edge where EVENT=1 and the previous registered EVENT=0. One action per press regardless of hold length.
- Latency: KEY/OP/flags sampled on the action edge; RESULT/STATE/OVF updated on that same edge, visible one clock after EVENT rises.
- Decode priority: CCLR > EQUAL > OPK > digit.
- States: IDLE=0, ENT_A=1, ENT_B=2, DONE=3. Codes 4-7 are unused and recover to IDLE on the next edge.
- Digit entry: operand <= ((operand << KEY_W) | KEY) masked to OPND_W. On the (NDIG+1)th digit the oldest digit is dropped. Digit count saturates at NDIG.
- CCLR, any state: ACC=0, B=0, OVF=0, pending op=add, go IDLE, RESULT=0.
- IDLE/ENT_A, digit: shift into ACC[OPND_W-1:0] (upper ACC bits 0), go ENT_A, RESULT=ACC.
- IDLE/ENT_A, op: pending op=OP, B=0, B count=0, go ENT_B. RESULT unchanged. Empty A counts as 0.
- IDLE/ENT_A, equal: go DONE, RESULT=ACC.
- ENT_B, digit: shift into B, RESULT=zero-extended B.
- ENT_B, op:
  - B count=0: only replace pending op.
  - B count>0: ACC=ACC pending B, RESULT=ACC, pending op=OP, B cleared. Stay ENT_B (chaining).
- ENT_B, equal: ACC=ACC pending B, last op=pending, last B=B, go DONE, RESULT=ACC. B count=0 uses B=0.
- DONE, equal: ACC=ACC last-op last-B (repeat), RESULT=ACC.
- DONE, op: keep ACC, pending op=OP, B=0, go ENT_B.
- DONE, digit: ACC=KEY, OVF=0, go ENT_A.
- Arithmetic is modulo 2^RES_W; B is zero-extended.
  - add: carry out sets OVF.
  - mul: full RES_W+OPND_W product; nonzero upper bits set OVF.
  - sub: ACC<B (borrow) sets OVF; result is two's-complement wrap.
  - and: never sets OVF.
- OVF is sticky until CCLR, reset, or a new A entry begins.
- EVENT with CCLR and EQUAL both set: clear only. OPK with EQUAL: equals only.
- Reset asserted mid-entry or mid-chain: immediate return to the reset values above. The first event after release is treated as a new press only if EVENT was 0 at release; an EVENT already held across release is ignored until it drops.

Test Plan:
1. Reset, keys a,1, op add, keys 5,f, equal -> RESULT 0x00A1, then 0x005F, then 0x0100; STATE 3; OVF 0.
2. CCLR, key b, op mul, keys f,3, equal -> RESULT 0x0A71, OVF 0; OP=01 matches legacy mul encoding.
3. Keys 2, op add, 3, op add (RESULT 0x0005), 4, equal -> 0x0009; equal again -> 0x000D; equal -> 0x0011.
4. Keys 0,5, op sub, 0,7, equal -> RESULT 0xFFFE, OVF 1. Then digit 3 -> RESULT 0x0003, OVF 0, STATE 1.
5. Keys f,f, mul, f,f, equal -> 0xFE01, OVF 0; op mul, f,f, equal -> 0x02FF, OVF 1. Keys 1,2,3 from IDLE -> 0x0023.
6. EVENT held 3 cycles with KEY=7 -> single digit (RESULT 0x0007). CLR_N pulsed low mid-ENT_B -> RESULT 0, STATE 0, OVF 0 asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/adv_calc_p.sv
// adv_calc_p: keypad calculator core with digit entry, add/mul/sub/and,
// chained operations, repeat-equals, sticky overflow and key edge detection.
//
// Parameters:
//   KEY_W  bits per digit key
//   NDIG   digits kept per operand (OPND_W = NDIG*KEY_W)
//   RES_W  accumulator / RESULT width, must be >= OPND_W
// Ports:
//   CLK     clock, rising edge
//   CLR_N   asynchronous active-low reset
//   KEY     digit value, sampled on a key action
//   OPK     event is an operator key, OP selects add/mul/sub/and
//   EQUAL   event is the equals key
//   CCLR    event is the clear key
//   EVENT   key-press level from the scanner; one action per rising edge
//   RESULT  displayed value (registered)
//   STATE   FSM state code (registered)
//   OVF     sticky overflow of the current computation chain (registered)
module adv_calc_p #(
  parameter int unsigned KEY_W = 4,
  parameter int unsigned NDIG  = 2,
  parameter int unsigned RES_W = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [KEY_W-1:0] KEY,
  input  logic             OPK,
  input  logic [1:0]       OP,
  input  logic             EQUAL,
  input  logic             CCLR,
  input  logic             EVENT,
  output logic [RES_W-1:0] RESULT,
  output logic [2:0]       STATE,
  output logic             OVF
);

  localparam int unsigned OPND_W = NDIG * KEY_W;
  localparam int unsigned CNT_W  = $clog2(NDIG + 1);
  localparam int unsigned PROD_W = RES_W + OPND_W;

  if (RES_W < OPND_W) begin : g_param_chk
    $error("adv_calc_p: RES_W must be >= NDIG*KEY_W");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENT_A = 3'd1,
    S_ENT_B = 3'd2,
    S_DONE  = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_AND = 2'b11
  } op_e;

  state_e             state_q,   state_d;
  logic [RES_W-1:0]   acc_q,     acc_d;
  logic [OPND_W-1:0]  b_q,       b_d;
  logic [CNT_W-1:0]   b_cnt_q,   b_cnt_d;
  op_e                pend_op_q, pend_op_d;
  op_e                last_op_q, last_op_d;
  logic [OPND_W-1:0]  last_b_q,  last_b_d;
  logic [RES_W-1:0]   result_q,  result_d;
  logic               ovf_q,     ovf_d;
  logic               event_q,   event_d;
  logic               block_q,   block_d;

  logic               act;
  logic [OPND_W-1:0]  a_shift;
  logic [OPND_W-1:0]  b_shift;
  op_e                alu_op;
  logic [OPND_W-1:0]  alu_b;
  logic [RES_W-1:0]   alu_b_ext;
  logic [RES_W:0]     sum_w;
  logic [PROD_W-1:0]  prod_w;
  logic [RES_W-1:0]   diff_w;
  logic [RES_W-1:0]   alu_res;
  logic               alu_ovf;

  // One action per press. block_q suppresses a press already held when
  // reset is released; it clears on the first edge that sees EVENT low.
  assign act = EVENT & ~event_q & ~block_q;

  // Digit shift: newest digit enters at the bottom, oldest falls off the top.
  assign a_shift = (acc_q[OPND_W-1:0] << KEY_W) | OPND_W'(KEY);
  assign b_shift = (b_q << KEY_W) | OPND_W'(KEY);

  // ALU operands: repeat-equals in DONE reuses the last op and operand.
  always_comb begin
    alu_op    = pend_op_q;
    alu_b     = b_q;
    if (state_q == S_DONE) begin
      alu_op = last_op_q;
      alu_b  = last_b_q;
    end
    alu_b_ext = RES_W'(alu_b);
    sum_w     = {1'b0, acc_q} + {1'b0, alu_b_ext};
    prod_w    = PROD_W'(acc_q) * PROD_W'(alu_b);
    diff_w    = acc_q - alu_b_ext;
  end

  // Result and overflow for each operator.
  always_comb begin
    alu_res = sum_w[RES_W-1:0];
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum_w[RES_W-1:0];
        alu_ovf = sum_w[RES_W];
      end
      OP_MUL: begin
        alu_res = prod_w[RES_W-1:0];
        alu_ovf = |prod_w[PROD_W-1:RES_W];
      end
      OP_SUB: begin
        alu_res = diff_w;
        alu_ovf = (acc_q < alu_b_ext);
      end
      OP_AND: begin
        alu_res = acc_q & alu_b_ext;
        alu_ovf = 1'b0;
      end
      default: begin
        alu_res = sum_w[RES_W-1:0];
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update; decode priority CCLR > EQUAL > OPK > digit.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_d       = b_q;
    b_cnt_d   = b_cnt_q;
    pend_op_d = pend_op_q;
    last_op_d = last_op_q;
    last_b_d  = last_b_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    event_d   = EVENT;
    block_d   = block_q & EVENT;

    if (act && CCLR) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      b_d       = '0;
      b_cnt_d   = '0;
      pend_op_d = OP_ADD;
      result_d  = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ENT_A: begin
          if (act) begin
            if (EQUAL) begin
              state_d  = S_DONE;
              result_d = acc_q;
            end else if (OPK) begin
              pend_op_d = op_e'(OP);
              b_d       = '0;
              b_cnt_d   = '0;
              state_d   = S_ENT_B;
            end else begin
              acc_d    = RES_W'(a_shift);
              result_d = RES_W'(a_shift);
              state_d  = S_ENT_A;
              if (state_q == S_IDLE) ovf_d = 1'b0;
            end
          end
        end

        S_ENT_B: begin
          if (act) begin
            if (EQUAL) begin
              acc_d     = alu_res;
              result_d  = alu_res;
              ovf_d     = ovf_q | alu_ovf;
              last_op_d = pend_op_q;
              last_b_d  = b_q;
              b_d       = '0;
              b_cnt_d   = '0;
              state_d   = S_DONE;
            end else if (OPK) begin
              pend_op_d = op_e'(OP);
              // With no B digits the operator key only changes the pending op.
              if (b_cnt_q != CNT_W'(0)) begin
                acc_d    = alu_res;
                result_d = alu_res;
                ovf_d    = ovf_q | alu_ovf;
                b_d      = '0;
                b_cnt_d  = '0;
              end
            end else begin
              b_d      = b_shift;
              result_d = RES_W'(b_shift);
              if (b_cnt_q != CNT_W'(NDIG)) b_cnt_d = b_cnt_q + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          if (act) begin
            if (EQUAL) begin
              acc_d    = alu_res;
              result_d = alu_res;
              ovf_d    = ovf_q | alu_ovf;
            end else if (OPK) begin
              pend_op_d = op_e'(OP);
              b_d       = '0;
              b_cnt_d   = '0;
              state_d   = S_ENT_B;
            end else begin
              acc_d    = RES_W'(KEY);
              result_d = RES_W'(KEY);
              ovf_d    = 1'b0;
              state_d  = S_ENT_A;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      b_q       <= '0;
      b_cnt_q   <= '0;
      pend_op_q <= OP_ADD;
      last_op_q <= OP_ADD;
      last_b_q  <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      event_q   <= 1'b0;
      block_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      b_cnt_q   <= b_cnt_d;
      pend_op_q <= pend_op_d;
      last_op_q <= last_op_d;
      last_b_q  <= last_b_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      event_q   <= event_d;
      block_q   <= block_d;
    end
  end

  assign RESULT = result_q;
  assign STATE  = state_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_adv_calc_p.sv
// Bench for adv_calc_p: key-press level model checked every cycle, plus
// literal checks from the hand-worked calculator sequences.
module tb_adv_calc_p;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned NDIG  = 2;
  localparam int unsigned RES_W = 16;

  localparam int M_IDLE = 0, M_ENT_A = 1, M_ENT_B = 2, M_DONE = 3;
  localparam longint RMASK = 64'hFFFF;
  localparam longint OMASK = 64'hFF;

  logic             clk;
  logic             CLR_N;
  logic [KEY_W-1:0] KEY;
  logic             OPK;
  logic [1:0]       OP;
  logic             EQUAL;
  logic             CCLR;
  logic             EVENT;
  logic [RES_W-1:0] RESULT;
  logic [2:0]       STATE;
  logic             OVF;

  adv_calc_p #(.KEY_W(KEY_W), .NDIG(NDIG), .RES_W(RES_W)) dut (
    .CLK(clk), .CLR_N(CLR_N), .KEY(KEY), .OPK(OPK), .OP(OP),
    .EQUAL(EQUAL), .CCLR(CCLR), .EVENT(EVENT),
    .RESULT(RESULT), .STATE(STATE), .OVF(OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Calculator model at key-press granularity.
  longint m_acc, m_b, m_lastb, m_result;
  int     m_pend, m_last, m_bcnt, m_state;
  bit     m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_b = 0; m_lastb = 0; m_result = 0;
    m_pend = 0; m_last = 0; m_bcnt = 0; m_state = M_IDLE; m_ovf = 0;
  endtask

  task automatic calc(input longint a, input int op, input longint b,
                      output longint res, output bit ov);
    longint t;
    case (op)
      0: begin t = a + b; ov = (t > RMASK); res = t & RMASK; end
      1: begin t = a * b; ov = (t > RMASK); res = t & RMASK; end
      2: begin ov = (a < b); res = (a - b) & RMASK; end
      default: begin ov = 0; res = a & b; end
    endcase
  endtask

  task automatic model_apply(input int key, input bit opk, input int op,
                             input bit eq, input bit cc);
    longint r;
    bit o;
    if (cc) begin
      m_acc = 0; m_b = 0; m_bcnt = 0; m_ovf = 0; m_pend = 0;
      m_state = M_IDLE; m_result = 0;
    end else if (m_state == M_IDLE || m_state == M_ENT_A) begin
      if (eq) begin
        m_state = M_DONE; m_result = m_acc;
      end else if (opk) begin
        m_pend = op; m_b = 0; m_bcnt = 0; m_state = M_ENT_B;
      end else begin
        if (m_state == M_IDLE) m_ovf = 0;
        m_acc = ((m_acc * 16) + key) & OMASK;
        m_result = m_acc; m_state = M_ENT_A;
      end
    end else if (m_state == M_ENT_B) begin
      if (eq) begin
        calc(m_acc, m_pend, m_b, r, o);
        m_acc = r; m_ovf = m_ovf | o; m_result = r;
        m_last = m_pend; m_lastb = m_b; m_b = 0; m_bcnt = 0;
        m_state = M_DONE;
      end else if (opk) begin
        if (m_bcnt != 0) begin
          calc(m_acc, m_pend, m_b, r, o);
          m_acc = r; m_ovf = m_ovf | o; m_result = r;
          m_b = 0; m_bcnt = 0;
        end
        m_pend = op;
      end else begin
        m_b = ((m_b * 16) + key) & OMASK;
        if (m_bcnt < NDIG) m_bcnt++;
        m_result = m_b;
      end
    end else begin
      if (eq) begin
        calc(m_acc, m_last, m_lastb, r, o);
        m_acc = r; m_ovf = m_ovf | o; m_result = r;
      end else if (opk) begin
        m_pend = op; m_b = 0; m_bcnt = 0; m_state = M_ENT_B;
      end else begin
        m_acc = key; m_ovf = 0; m_state = M_ENT_A; m_result = key;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("result", 32'(RESULT), 32'(m_result));
      check("state",  32'(STATE),  32'(m_state));
      check("ovf",    32'(OVF),    32'(m_ovf));
    end
  end

  task automatic press(input int key, input bit opk, input int op, input bit eq,
                       input bit cc, input int hold, input int gap);
    @(negedge clk); #1;
    KEY = 4'(key); OPK = opk; OP = 2'(op); EQUAL = eq; CCLR = cc; EVENT = 1'b1;
    model_apply(key, opk, op, eq, cc);
    repeat (hold) @(negedge clk);
    #1;
    EVENT = 1'b0; OPK = 1'b0; EQUAL = 1'b0; CCLR = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic dig(input int k); press(k, 0, 0, 0, 0, 1, 1); endtask
  task automatic opr(input int o); press(0, 1, o, 0, 0, 1, 1); endtask
  task automatic eqk();            press(0, 0, 0, 1, 0, 1, 1); endtask
  task automatic clr();            press(0, 0, 0, 0, 1, 1, 1); endtask

  task automatic lit(input string name, input logic [15:0] r, input int st, input bit ov);
    check({name, ".result"}, 32'(RESULT), 32'(r));
    check({name, ".state"},  32'(STATE),  32'(st));
    check({name, ".ovf"},    32'(OVF),    32'(ov));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    CLR_N = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 CLR_N = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int r;
    CLR_N = 1'b0; KEY = '0; OPK = 0; OP = '0; EQUAL = 0; CCLR = 0; EVENT = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    lit("reset", 16'h0000, 0, 0);
    @(posedge clk); #2 CLR_N = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // 1: a1 + 5f = 0x100
    dig(4'ha); lit("t1.a", 16'h000A, 1, 0);
    dig(4'h1); lit("t1.a1", 16'h00A1, 1, 0);
    opr(0);    lit("t1.op", 16'h00A1, 2, 0);
    dig(4'h5); dig(4'hf); lit("t1.b", 16'h005F, 2, 0);
    eqk();     lit("t1.eq", 16'h0100, 3, 0);

    // 2: b * f3 = 0xa71
    clr(); lit("t2.clr", 16'h0000, 0, 0);
    dig(4'hb); opr(1); dig(4'hf); dig(4'h3); eqk();
    lit("t2.eq", 16'h0A71, 3, 0);

    // 3: chaining and repeat-equals
    clr(); dig(2); opr(0); dig(3); opr(0);
    lit("t3.chain", 16'h0005, 2, 0);
    dig(4); eqk(); lit("t3.eq1", 16'h0009, 3, 0);
    eqk(); lit("t3.eq2", 16'h000D, 3, 0);
    eqk(); lit("t3.eq3", 16'h0011, 3, 0);

    // 4: borrow, then new A entry clears OVF
    clr(); dig(0); dig(5); opr(2); dig(0); dig(7); eqk();
    lit("t4.sub", 16'hFFFE, 3, 1);
    dig(3); lit("t4.newa", 16'h0003, 1, 0);

    // 5: multiply overflow, digit drop
    clr(); dig(15); dig(15); opr(1); dig(15); dig(15); eqk();
    lit("t5.mul1", 16'hFE01, 3, 0);
    opr(1); dig(15); dig(15); eqk();
    lit("t5.mul2", 16'h02FF, 3, 1);
    clr(); dig(1); dig(2); dig(3);
    lit("t5.drop", 16'h0023, 1, 0);

    // Combined flags: OPK+EQUAL acts as equals, CCLR+EQUAL clears only
    clr(); dig(1); opr(0); dig(2);
    press(0, 1, 1, 1, 0, 1, 1); lit("opk_eq", 16'h0003, 3, 0);
    press(0, 0, 0, 1, 1, 1, 1); lit("cclr_eq", 16'h0000, 0, 0);

    // 6: held EVENT gives one digit; async reset mid-ENT_B
    press(7, 0, 0, 0, 0, 3, 1); lit("t6.hold", 16'h0007, 1, 0);
    opr(0); dig(5); lit("t6.entb", 16'h0005, 2, 0);
    @(posedge clk); #2;
    CLR_N = 1'b0; model_reset();
    #1 lit("t6.async", 16'h0000, 0, 0);
    // Key held across reset release must be ignored until it drops.
    KEY = 4'h9; EVENT = 1'b1;
    @(posedge clk); #2 CLR_N = 1'b1;
    repeat (3) @(negedge clk);
    lit("t6.held", 16'h0000, 0, 0);
    #1 EVENT = 1'b0;
    repeat (2) @(negedge clk);
    dig(9); lit("t6.after", 16'h0009, 1, 0);

    // Randomized key sequences against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      press($urandom_range(0, 15), 0, 0, 0, 0, $urandom_range(1, 3), $urandom_range(1, 2));
      else if (r < 75) press($urandom_range(0, 15), 1, $urandom_range(0, 3), 0, 0, $urandom_range(1, 3), $urandom_range(1, 2));
      else if (r < 90) press($urandom_range(0, 15), 0, 0, 1, 0, $urandom_range(1, 3), $urandom_range(1, 2));
      else if (r < 94) press($urandom_range(0, 15), 0, 0, 0, 1, 1, 1);
      else if (r < 97) press($urandom_range(0, 15), 1, $urandom_range(0, 3), 1, 0, 1, 1);
      else             press($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3), 1, 1, 1, 1);
      if (i % 131 == 130) do_reset();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
